// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - circular FIFO controller driving a single-port synchronous memory
// Arbitrates push vs pop onto one memory port; popped data returns one cycle later.
module mem_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              prio;
  logic              ov;
  logic              can_pop;
  logic              can_push;
  logic              contend;
  logic              pop_fire;
  logic              push_fire;

  assign empty     = (cnt == '0);
  assign full      = (cnt == FULL_CNT);
  assign count     = cnt;
  assign out_valid = ov;
  assign out_data  = mem_dout;

  // Only a real two-sided request is contention; prio breaks the tie.
  always_comb begin
    can_pop    = pop_req && !empty;
    can_push   = push_valid && !full;
    contend    = can_pop && can_push;
    pop_ready  = rst_n && !empty && !(contend && prio);
    push_ready = rst_n && !full && !(contend && !prio);
    pop_fire   = pop_req && pop_ready;
    push_fire  = push_valid && push_ready;
  end

  always_comb begin
    mem_ren  = pop_fire;
    mem_wen  = push_fire;
    mem_addr = push_fire ? wr_ptr : rd_ptr;
    mem_din  = push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      prio   <= 1'b0;
      ov     <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      if (push_fire && !pop_fire)
        cnt <= cnt + 1'b1;
      else if (pop_fire && !push_fire)
        cnt <= cnt - 1'b1;
      if (contend) prio <= ~prio;
      ov <= pop_fire;
    end
  end

endmodule
